// File: rtl/ps2_key_encoder.sv
// PS/2 device-to-host deserialiser producing the 11-bit toggle-event ps2_key word.
// Handles input filtering, framing/parity, E0/F0 prefixes, the E1 Pause run and frame timeouts.
module ps2_key_encoder #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 12000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Index 0 carries ps2_clk, index 1 carries ps2_data.
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          clk_prev_q;
  logic          fall;
  logic          data_f;

  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    byte_q;
  logic          byte_vld_q;
  logic          ext_q, rel_q;
  logic [2:0]    skip_q;

  assign fall   = clk_prev_q & ~filt_q[0];
  assign data_f = filt_q[1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      sync1_q    <= {ps2_data, ps2_clk};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= ~filt_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      to_cnt_q   <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      skip_q     <= '0;
      ps2_key    <= '0;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
      byte_vld_q <= 1'b0;

      // Prefix decoder: runs the cycle after a valid stop bit.
      if (byte_vld_q) begin
        if (skip_q != '0) begin
          skip_q <= skip_q - 1'b1;
        end else if (byte_q == 8'hE1) begin
          skip_q <= 3'd7;
        end else if (byte_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          rel_q <= 1'b1;
        end else begin
          ps2_key    <= {~ps2_key[10], ~rel_q, ext_q, byte_q};
          key_strobe <= 1'b1;
          ext_q      <= 1'b0;
          rel_q      <= 1'b0;
        end
      end

      if (state_q == StIdle || fall) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TW'(TIMEOUT_CYC - 1)) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (fall) begin
        case (state_q)
          StIdle: begin
            if (!data_f) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
              shift_q   <= '0;
            end
          end
          StData: begin
            shift_q   <= {data_f, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            parity_q <= data_f;
            state_q  <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (data_f && ((^shift_q) ^ parity_q)) begin
              byte_q     <= shift_q;
              byte_vld_q <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              ext_q     <= 1'b0;
              rel_q     <= 1'b0;
              skip_q    <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q != StIdle && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        // Timeout abort; a fall in the same cycle takes priority above.
        state_q   <= StIdle;
        to_cnt_q  <= '0;
        frame_err <= 1'b1;
        ext_q     <= 1'b0;
        rel_q     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: drives PS/2 frames, checks against an event-level model.
module tb_ps2_key_encoder;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 12000;
  localparam int unsigned HALF = 60;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  ps2_key_encoder #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .key_strobe(key_strobe),
    .frame_err (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Event-level model of the key stream.
  bit          m_ext, m_rel, m_tog;
  int          m_skip;
  logic [10:0] exp_q[$];
  int          exp_errs = 0;
  int          seen_errs = 0;
  logic [10:0] exp_hold = '0;
  int          stop_cyc = 0;
  bit          err_lat_pending = 0;

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 0; m_rel = 0; m_skip = 0;
      exp_errs++;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else begin
      m_tog = ~m_tog;
      exp_q.push_back({m_tog, ~m_rel, m_ext, b});
      m_ext = 0; m_rel = 0;
    end
  endfunction

  // Compare process: every cycle, away from the active edge.
  bit prev_strobe = 0;
  bit prev_err = 0;
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        exp_hold    = '0;
        prev_strobe = 0;
        prev_err    = 0;
      end else begin
        if (key_strobe) begin
          check("event_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_hold = exp_q.pop_front();
            check("strobe_latency", cyc - stop_cyc, FL + 4);
          end
        end
        if (frame_err) begin
          seen_errs++;
          if (err_lat_pending) begin
            check("err_latency", cyc - stop_cyc, FL + 3);
            err_lat_pending = 0;
          end
        end
        check("pulse_width", 32'((key_strobe && prev_strobe) || (frame_err && prev_err)), 0);
        prev_strobe = key_strobe;
        prev_err    = frame_err;
      end
      check("ps2_key", ps2_key, exp_hold);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Drives the first n bits of an 11-bit frame; optional 3-cycle clock glitch in bit glitch_bit.
  task automatic drive_bits(input logic [10:0] fr, input int n, input int glitch_bit, input bit ok);
    for (int i = 0; i < n; i++) begin
      ps2_data = fr[i];
      if (i == glitch_bit) begin
        wait_cyc(20);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 23);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      if (i == 10) begin
        stop_cyc        = cyc;
        err_lat_pending = !ok;
      end
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit ok);
    logic par;
    par = ok ? ~^b : ^b;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b, input bit ok = 1, input int glitch_bit = -1);
    model_byte(b, ok);
    drive_bits(mk_frame(b, ok), 11, glitch_bit, ok);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  logic [7:0] pause_seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h5A};

  initial begin
    wait_cyc(3);
    check("rst_key", ps2_key, 0);
    check("rst_strobe", key_strobe, 0);
    check("rst_err", frame_err, 0);
    reset_n = 1'b1;
    wait_cyc(20);

    // Make code 0x1C
    send(8'h1C);
    wait_cyc(20);
    check("t1_key", ps2_key, 11'h61C);

    // Extended up-arrow release
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    wait_cyc(20);
    check("t2_key", ps2_key, 11'h175);

    // Parity error then valid 0x29
    send(8'h29, 0);
    wait_cyc(20);
    check("t3_key_held", ps2_key, 11'h175);
    check("t3_errs", seen_errs, 1);
    send(8'h29);
    wait_cyc(20);
    check("t3_key", ps2_key, 11'h629);

    // Glitches (idle with data low, and inside a frame), then timeout abort
    ps2_data = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    ps2_data = 1'b1;
    wait_cyc(100);
    send(8'h16, 1, 3);
    wait_cyc(20);
    check("t4_glitch_key", ps2_key, 11'h216);
    drive_bits(mk_frame(8'h16, 1), 5, -1, 1);
    m_ext = 0; m_rel = 0;
    exp_errs++;
    wait_cyc(TO + 200);
    check("t4_timeout_errs", seen_errs, 2);
    ps2_data = 1'b1;
    send(8'h16);
    wait_cyc(20);
    check("t4_key", ps2_key, 11'h616);

    // Pause sequence swallowed, then 0x5A
    foreach (pause_seq[i]) send(pause_seq[i]);
    wait_cyc(20);
    check("t5_key", ps2_key, 11'h25A);

    // Reset mid-frame after an E0 prefix
    send(8'hE0);
    drive_bits(mk_frame(8'h6B, 1), 4, -1, 1);
    wait_cyc(10);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_key", ps2_key, 0);
    check("t6_rst_strobe", key_strobe, 0);
    check("t6_rst_err", frame_err, 0);
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    m_ext = 0; m_rel = 0; m_tog = 0; m_skip = 0;
    exp_q.delete();
    err_lat_pending = 0;
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(50);
    send(8'h6B);
    wait_cyc(20);
    check("t6_key", ps2_key, 11'h66B);

    check("err_count", seen_errs, exp_errs);
    check("events_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
